// File: rtl/prng_pkg.sv
// Shared constants for the three-LFSR PRNG: register lengths, feedback taps,
// default seeds and the seed-word slice each LFSR loads from.
package prng_pkg;

    localparam int A_LEN = 17;
    localparam int B_LEN = 23;
    localparam int C_LEN = 31;

    localparam int A_TAP_HI = 16;
    localparam int A_TAP_LO = 13;
    localparam int B_TAP_HI = 22;
    localparam int B_TAP_LO = 17;
    localparam int C_TAP_HI = 30;
    localparam int C_TAP_LO = 27;

    localparam logic [A_LEN-1:0] A_SEED_DEF = 17'h00001;
    localparam logic [B_LEN-1:0] B_SEED_DEF = 23'h000001;
    localparam logic [C_LEN-1:0] C_SEED_DEF = 31'h00000001;

    // Each slice is exactly as wide as its LFSR; B deliberately takes the top bits.
    localparam int A_SLICE_HI = 16;
    localparam int A_SLICE_LO = 0;
    localparam int B_SLICE_HI = 31;
    localparam int B_SLICE_LO = 9;
    localparam int C_SLICE_HI = 30;
    localparam int C_SLICE_LO = 0;

endpackage

// File: rtl/lfsr_fib.sv
// Fibonacci LFSR, shifting left with the two-tap feedback entering bit 0.
// A load of all zeros is replaced by SEED so the register never locks up.
module lfsr_fib #(
    parameter int             LEN    = 17,
    parameter int             TAP_HI = 16,
    parameter int             TAP_LO = 13,
    parameter logic [LEN-1:0] SEED   = {{(LEN-1){1'b0}}, 1'b1}
) (
    input  logic           clksrc,
    input  logic           rstn,
    input  logic           shift,
    input  logic           load,
    input  logic [LEN-1:0] load_val,
    output logic [LEN-1:0] state
);

    logic [LEN-1:0] state_q;
    logic [LEN-1:0] state_d;

    // Load takes priority over shift.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_val == '0) ? SEED : load_val;
        end else if (shift) begin
            state_d = {state_q[LEN-2:0], state_q[TAP_HI] ^ state_q[TAP_LO]};
        end
    end

    always_ff @(posedge clksrc) begin
        if (!rstn) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/multi_lfsr_prng.sv
// Steps three LFSRs on each enabled rising edge of step_clk and publishes the
// XOR of their low bits one cycle later, with a single-cycle valid pulse.
module multi_lfsr_prng
    import prng_pkg::*;
#(
    parameter int                WIDTH  = 16,
    parameter logic [A_LEN-1:0]  SEED17 = A_SEED_DEF,
    parameter logic [B_LEN-1:0]  SEED23 = B_SEED_DEF,
    parameter logic [C_LEN-1:0]  SEED31 = C_SEED_DEF
) (
    input  logic             clksrc,
    input  logic             rstn,
    input  logic             step_clk,
    input  logic             en,
    input  logic             load,
    input  logic [31:0]      seed,
    output logic [WIDTH-1:0] rnd,
    output logic             rnd_valid
);

    logic             step_q;
    logic             step_d;
    logic             pend_q;
    logic             pend_d;
    logic [WIDTH-1:0] rnd_q;
    logic [WIDTH-1:0] rnd_d;
    logic             rnd_valid_q;
    logic             rnd_valid_d;
    logic             step_edge;
    logic             shift;
    logic [A_LEN-1:0] a_state;
    logic [B_LEN-1:0] b_state;
    logic [C_LEN-1:0] c_state;

    assign step_edge = step_clk & ~step_q & en;
    assign shift     = step_edge & ~load;

    lfsr_fib #(.LEN(A_LEN), .TAP_HI(A_TAP_HI), .TAP_LO(A_TAP_LO), .SEED(SEED17)) u_lfsr_a (
        .clksrc   (clksrc),
        .rstn     (rstn),
        .shift    (shift),
        .load     (load),
        .load_val (seed[A_SLICE_HI:A_SLICE_LO]),
        .state    (a_state)
    );

    lfsr_fib #(.LEN(B_LEN), .TAP_HI(B_TAP_HI), .TAP_LO(B_TAP_LO), .SEED(SEED23)) u_lfsr_b (
        .clksrc   (clksrc),
        .rstn     (rstn),
        .shift    (shift),
        .load     (load),
        .load_val (seed[B_SLICE_HI:B_SLICE_LO]),
        .state    (b_state)
    );

    lfsr_fib #(.LEN(C_LEN), .TAP_HI(C_TAP_HI), .TAP_LO(C_TAP_LO), .SEED(SEED31)) u_lfsr_c (
        .clksrc   (clksrc),
        .rstn     (rstn),
        .shift    (shift),
        .load     (load),
        .load_val (seed[C_SLICE_HI:C_SLICE_LO]),
        .state    (c_state)
    );

    // pend_q marks the cycle after a shift, when the LFSRs hold post-shift state.
    always_comb begin
        step_d      = step_clk;
        pend_d      = shift;
        rnd_valid_d = pend_q;
        rnd_d       = rnd_q;
        if (pend_q) begin
            rnd_d = a_state[WIDTH-1:0] ^ b_state[WIDTH-1:0] ^ c_state[WIDTH-1:0];
        end
    end

    always_ff @(posedge clksrc) begin
        if (!rstn) begin
            step_q      <= 1'b0;
            pend_q      <= 1'b0;
            rnd_q       <= '0;
            rnd_valid_q <= 1'b0;
        end else begin
            step_q      <= step_d;
            pend_q      <= pend_d;
            rnd_q       <= rnd_d;
            rnd_valid_q <= rnd_valid_d;
        end
    end

    assign rnd       = rnd_q;
    assign rnd_valid = rnd_valid_q;

endmodule
